// File: rtl/doc_wave_fetch_pkg.sv
// Shared sound-side definitions: fetch FSM states, sound RAM placement, cache geometry.
package doc_wave_fetch_pkg;

  localparam logic [20:0] SOUND_RAM_BASE_WORD = 21'h01_0000;
  localparam int          NUM_LINES           = 4;
  localparam int          IDX_W               = $clog2(NUM_LINES);
  localparam int          WORD_W              = 14;             // 64K bytes as 32-bit words
  localparam int          TAG_W               = WORD_W - IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    MISS_WAIT,
    RESPOND
  } wave_state_e;

  // Pick byte b out of a little-endian 32-bit word.
  function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] b);
    return w[{b, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/doc_wave_line_store.sv
// Direct-mapped line store: data, tags, valid bits and the hit compare.
module doc_wave_line_store
  import doc_wave_fetch_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [WORD_W-1:0] lookup_word,
  output logic              hit,
  output logic [31:0]       hit_data,
  input  logic              inv,
  input  logic [WORD_W-1:0] inv_word,
  input  logic              fill,
  input  logic [WORD_W-1:0] fill_word,
  input  logic [31:0]       fill_data
);

  logic [NUM_LINES-1:0]             valid;
  logic [NUM_LINES-1:0][TAG_W-1:0]  tag_q;
  logic [NUM_LINES-1:0][31:0]       data_q;

  logic [IDX_W-1:0] lidx, iidx, fidx;
  assign lidx = lookup_word[IDX_W-1:0];
  assign iidx = inv_word[IDX_W-1:0];
  assign fidx = fill_word[IDX_W-1:0];

  // Tag compare against the addressed line.
  always_comb begin
    hit      = valid[lidx] && (tag_q[lidx] == lookup_word[WORD_W-1:IDX_W]);
    hit_data = data_q[lidx];
  end

  // Valid bits: invalidate a matching line; a fill to the same index lands last and wins.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid <= '0;
    end else begin
      if (inv && valid[iidx] && (tag_q[iidx] == inv_word[WORD_W-1:IDX_W]))
        valid[iidx] <= 1'b0;
      if (fill)
        valid[fidx] <= 1'b1;
    end
  end

  // Tag and data arrays need no reset; valid bits qualify them.
  always_ff @(posedge clk_i) begin
    if (fill) begin
      tag_q[fidx]  <= fill_word[WORD_W-1:IDX_W];
      data_q[fidx] <= fill_data;
    end
  end

endmodule

// File: rtl/doc_wave_fetch.sv
// DOC wave-read front end: 4-line cache over the SDRAM-resident sound RAM.
module doc_wave_fetch
  import doc_wave_fetch_pkg::*;
#(
  parameter bit          ENABLE    = 1'b1,
  parameter logic [20:0] BASE_WORD = SOUND_RAM_BASE_WORD
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        wave_rd_i,
  input  logic [15:0] wave_addr_i,
  output logic [7:0]  wave_data_o,
  output logic        wave_data_ready_o,
  input  logic        glu_wr_i,
  input  logic [15:0] glu_addr_i,
  output logic        mem_rd_o,
  output logic [20:0] mem_addr_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_q_i,
  output logic        overrun_o
);

  wave_state_e state, state_nxt;

  logic [15:0] addr_q, pend_addr;
  logic        pend_v, no_alloc;
  logic [31:0] fill_q;
  logic        ls_hit;
  logic [31:0] ls_data;
  logic        glu_match, lookup_hit;
  logic        resp_fire, rd_fire, fill_we;
  logic [7:0]  resp_byte;

  // GLU writes are byte-granular but invalidation works on whole words.
  logic unused_glu_lsb;
  assign unused_glu_lsb = ^glu_addr_i[1:0];

  // A GLU write to the word being looked up or filled beats the cached copy.
  assign glu_match  = glu_wr_i && (glu_addr_i[15:2] == addr_q[15:2]);
  assign lookup_hit = ENABLE && ls_hit && !glu_match;
  assign mem_addr_o = BASE_WORD + {7'd0, addr_q[15:2]};

  doc_wave_line_store u_lines (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .lookup_word (addr_q[15:2]),
    .hit         (ls_hit),
    .hit_data    (ls_data),
    .inv         (glu_wr_i),
    .inv_word    (glu_addr_i[15:2]),
    .fill        (fill_we),
    .fill_word   (addr_q[15:2]),
    .fill_data   (mem_q_i)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (pend_v || wave_rd_i) state_nxt = LOOKUP;
      LOOKUP:    state_nxt = (!ENABLE || lookup_hit) ? IDLE : MISS_WAIT;
      MISS_WAIT: if (mem_ready_i) state_nxt = RESPOND;
      RESPOND:   state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Per-state actions: respond, issue a read, or write the fill into the store.
  always_comb begin
    resp_fire = 1'b0;
    resp_byte = 8'h00;
    rd_fire   = 1'b0;
    fill_we   = 1'b0;
    case (state)
      LOOKUP: begin
        if (!ENABLE) begin
          resp_fire = 1'b1;
        end else if (lookup_hit) begin
          resp_fire = 1'b1;
          resp_byte = sel_byte(ls_data, addr_q[1:0]);
        end else begin
          rd_fire = 1'b1;
        end
      end
      MISS_WAIT: fill_we = mem_ready_i && !no_alloc && !glu_match;
      RESPOND: begin
        resp_fire = 1'b1;
        resp_byte = sel_byte(fill_q, addr_q[1:0]);
      end
      default: ;
    endcase
  end

  // Request intake: current address, one-deep pending slot, sticky overrun.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      addr_q    <= '0;
      pend_v    <= 1'b0;
      pend_addr <= '0;
      overrun_o <= 1'b0;
    end else if (state == IDLE) begin
      if (pend_v) begin
        addr_q <= pend_addr;
        pend_v <= wave_rd_i;              // slot frees this cycle, so a new pulse refills it
        if (wave_rd_i) pend_addr <= wave_addr_i;
      end else if (wave_rd_i) begin
        addr_q <= wave_addr_i;
      end
    end else if (wave_rd_i) begin
      if (pend_v) begin
        overrun_o <= 1'b1;
      end else begin
        pend_v    <= 1'b1;
        pend_addr <= wave_addr_i;
      end
    end
  end

  // Registered outputs, fill word capture and no-allocate tracking.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wave_data_o       <= 8'h00;
      wave_data_ready_o <= 1'b0;
      mem_rd_o          <= 1'b0;
      fill_q            <= '0;
      no_alloc          <= 1'b0;
    end else begin
      wave_data_ready_o <= resp_fire;
      mem_rd_o          <= rd_fire;
      if (resp_fire) wave_data_o <= resp_byte;
      if (state == MISS_WAIT && mem_ready_i) fill_q <= mem_q_i;
      if (state == IDLE)
        no_alloc <= 1'b0;
      else if (glu_match && (state == LOOKUP || state == MISS_WAIT))
        no_alloc <= 1'b1;
    end
  end

endmodule

// File: tb/tb_doc_wave_fetch.sv
// Directed bench for doc_wave_fetch: scoreboard of expected bytes, SDRAM responder model.
module tb_doc_wave_fetch;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        wave_rd_i;
  logic [15:0] wave_addr_i;
  logic [7:0]  wave_data_o;
  logic        wave_data_ready_o;
  logic        glu_wr_i;
  logic [15:0] glu_addr_i;
  logic        mem_rd_o;
  logic [20:0] mem_addr_o;
  logic        mem_ready_i;
  logic [31:0] mem_q_i;
  logic        overrun_o;

  logic [7:0]  dis_data;
  logic        dis_ready, dis_mem_rd, dis_overrun;
  logic [20:0] dis_mem_addr;

  always #5 clk_i = ~clk_i;

  doc_wave_fetch #(.ENABLE(1'b1)) u_dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .wave_rd_i(wave_rd_i), .wave_addr_i(wave_addr_i),
    .wave_data_o(wave_data_o), .wave_data_ready_o(wave_data_ready_o),
    .glu_wr_i(glu_wr_i), .glu_addr_i(glu_addr_i),
    .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o),
    .mem_ready_i(mem_ready_i), .mem_q_i(mem_q_i),
    .overrun_o(overrun_o)
  );

  doc_wave_fetch #(.ENABLE(1'b0)) u_dis (
    .clk_i(clk_i), .reset_i(reset_i),
    .wave_rd_i(wave_rd_i), .wave_addr_i(wave_addr_i),
    .wave_data_o(dis_data), .wave_data_ready_o(dis_ready),
    .glu_wr_i(glu_wr_i), .glu_addr_i(glu_addr_i),
    .mem_rd_o(dis_mem_rd), .mem_addr_o(dis_mem_addr),
    .mem_ready_i(mem_ready_i), .mem_q_i(mem_q_i),
    .overrun_o(dis_overrun)
  );

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         rd_count = 0;
  int         ready_count = 0;
  int         last_ready_cyc = 0;
  int         req_cyc = 0;
  int         dis_rd_seen = 0;
  int         dis_ready_count = 0;
  logic [20:0] last_mem_addr = '0;
  logic [7:0] sb[$];

  always @(posedge clk_i) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // SDRAM contents: the documented word, otherwise a distinct per-byte pattern.
  function automatic logic [31:0] mem_word(input logic [20:0] wa);
    if (wa == 21'h01_048D) return 32'hDDCC_BBAA;
    return {wa[7:0] ^ 8'h33, wa[7:0] ^ 8'hC5, wa[7:0] ^ 8'h7E, wa[7:0] ^ 8'h96};
  endfunction

  function automatic logic [7:0] exp_byte(input logic [15:0] a);
    logic [31:0] w;
    w = mem_word(21'h01_0000 + {7'd0, a[15:2]});
    return w[{a[1:0], 3'b000} +: 8];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic req(input logic [15:0] a);
    wave_rd_i   = 1'b1;
    wave_addr_i = a;
    req_cyc     = cyc;
    tick(1);
    wave_rd_i   = 1'b0;
  endtask

  task automatic wait_drain(input int max);
    int k = 0;
    while (sb.size() != 0 && k < max) begin tick(1); k++; end
    chk("drain", sb.size(), 0);
    tick(3);
  endtask

  // Output monitors: scoreboard pops on each ready, read counting, disabled-instance checks.
  always @(negedge clk_i) begin
    if (mem_rd_o) begin rd_count++; last_mem_addr = mem_addr_o; end
    if (wave_data_ready_o) begin
      ready_count++;
      last_ready_cyc = cyc;
      if (sb.size() == 0) chk("spurious_ready", 1, 0);
      else chk("wave_data", wave_data_o, sb.pop_front());
    end
    if (dis_mem_rd) dis_rd_seen++;
    if (dis_ready) begin
      dis_ready_count++;
      chk("dis_data", dis_data, 8'h00);
    end
  end

  // SDRAM responder: fixed 3-cycle read latency, one-cycle data-valid pulse.
  initial begin
    logic [20:0] a;
    mem_ready_i = 1'b0;
    mem_q_i     = '0;
    forever begin
      @(negedge clk_i);
      if (mem_rd_o) begin
        a = mem_addr_o;
        repeat (3) @(posedge clk_i);
        #1;
        mem_ready_i = 1'b1;
        mem_q_i     = mem_word(a);
        @(posedge clk_i);
        #1;
        mem_ready_i = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    int rd0, rdy0, k;
    reset_i = 1'b1; wave_rd_i = 1'b0; wave_addr_i = '0;
    glu_wr_i = 1'b0; glu_addr_i = '0;
    tick(3);
    chk("rst_ready", wave_data_ready_o, 0);
    chk("rst_data", wave_data_o, 8'h00);
    chk("rst_mem_rd", mem_rd_o, 0);
    chk("rst_overrun", overrun_o, 0);
    reset_i = 1'b0;
    tick(2);

    // Cold read.
    rd0 = rd_count;
    sb.push_back(8'hBB);
    req(16'h1235);
    wait_drain(40);
    chk("cold_rd_count", rd_count - rd0, 1);
    chk("cold_mem_addr", last_mem_addr, 21'h01_048D);

    // Hit on the same word, two-cycle latency, no SDRAM access.
    rd0 = rd_count;
    sb.push_back(8'hCC);
    req(16'h1236);
    wait_drain(40);
    chk("hit_rd_count", rd_count - rd0, 0);
    chk("hit_latency", last_ready_cyc - req_cyc, 2);
    chk("data_hold", wave_data_o, 8'hCC);

    // GLU write invalidates the line; next read refetches.
    glu_wr_i = 1'b1; glu_addr_i = 16'h1234;
    tick(1);
    glu_wr_i = 1'b0;
    rd0 = rd_count;
    sb.push_back(exp_byte(16'h1234));
    req(16'h1234);
    wait_drain(40);
    chk("inv_rd_count", rd_count - rd0, 1);

    // Refilled line serves byte 3 as a hit.
    rd0 = rd_count;
    sb.push_back(8'hDD);
    req(16'h1237);
    wait_drain(40);
    chk("hit_b3_rd_count", rd_count - rd0, 0);

    // Back-to-back: A misses, B pends, C overruns.
    rd0 = rd_count;
    sb.push_back(exp_byte(16'h2001));
    sb.push_back(exp_byte(16'h3002));
    req(16'h2001);
    req(16'h3002);
    req(16'h4003);
    wait_drain(80);
    tick(10);
    chk("b2b_rd_count", rd_count - rd0, 2);
    chk("b2b_overrun", overrun_o, 1);

    // GLU write during lookup of a cached word forces a miss and no-allocate.
    rd0 = rd_count;
    sb.push_back(exp_byte(16'h3003));
    req(16'h3003);
    glu_wr_i = 1'b1; glu_addr_i = 16'h3001;
    tick(1);
    glu_wr_i = 1'b0;
    wait_drain(40);
    chk("collide_rd_count", rd_count - rd0, 1);
    rd0 = rd_count;
    sb.push_back(exp_byte(16'h3000));
    req(16'h3000);
    wait_drain(40);
    chk("noalloc_rd_count", rd_count - rd0, 1);

    // Reset while waiting on SDRAM; late data must not produce a ready.
    rd0 = rd_count;
    rdy0 = ready_count;
    req(16'h5000);
    k = 0;
    while (rd_count == rd0 && k < 20) begin tick(1); k++; end
    chk("rst_miss_rd_seen", rd_count - rd0, 1);
    reset_i = 1'b1;
    tick(1);
    reset_i = 1'b0;
    tick(8);
    chk("rst_miss_no_ready", ready_count - rdy0, 0);
    chk("rst_miss_overrun", overrun_o, 0);

    // All lines invalid after reset: previously cached word misses again.
    rd0 = rd_count;
    sb.push_back(8'hCC);
    req(16'h1236);
    wait_drain(40);
    chk("post_rst_rd_count", rd_count - rd0, 1);

    // Disabled instance never touched SDRAM yet still answered.
    chk("dis_no_mem_rd", dis_rd_seen, 0);
    chk("dis_ready_seen", dis_ready_count > 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/doc_wave_fetch.md
DOC_WAVE_FETCH -- requirements
Module: doc_wave_fetch

Interface
REQ-001 Parameter ENABLE, default 1'b1: when 0, no memory reads are issued and every request completes as a miss returning 8'h00.
REQ-002 Parameter BASE_WORD, default 21'h01_0000: 32-bit-word base of the 64K sound RAM in SDRAM.
REQ-003 Port clk_i  in  1: logic clock (clk_logic); single clock domain.
REQ-004 Port reset_i  in  1: reset, synchronous, active-high.
REQ-005 Port wave_rd_i  in  1: one-cycle DOC wave-read request pulse.
REQ-006 Port wave_addr_i  in  16: sound-RAM byte address, valid when wave_rd_i=1.
REQ-007 Port wave_data_o  out  8: returned byte, valid when wave_data_ready_o=1.
REQ-008 Port wave_data_ready_o  out  1: one-cycle completion pulse.
REQ-009 Port glu_wr_i  in  1: GLU sound-RAM byte-write pulse.
REQ-010 Port glu_addr_i  in  16: byte address of the GLU write.
REQ-011 Port mem_rd_o  out  1: one-cycle SDRAM read request pulse.
REQ-012 Port mem_addr_o  out  21: word address = BASE_WORD + addr[15:2].
REQ-013 Port mem_ready_i  in  1: SDRAM read-data-valid pulse.
REQ-014 Port mem_q_i  in  32: SDRAM read data, byte n at bits [8n+7:8n].
REQ-015 Port overrun_o  out  1: sticky flag, set when a request is dropped.

Function
REQ-016 Cache: 4 direct-mapped lines, index addr[3:2], tag addr[15:4], one valid bit per line, 32-bit data per line.
REQ-017 FSM states IDLE, LOOKUP, MISS_WAIT, RESPOND; reset state IDLE.
REQ-018 IDLE + wave_rd_i: latch address -> LOOKUP.
REQ-019 LOOKUP hit: wave_data_o = selected byte (addr[1:0]); assert ready for one cycle -> IDLE; hit latency is exactly 2 cycles from wave_rd_i to ready.
REQ-020 LOOKUP miss: pulse mem_rd_o for exactly one cycle with mem_addr_o held stable until the fill -> MISS_WAIT.
REQ-021 MISS_WAIT + mem_ready_i: write the line and set its valid bit (subject to REQ-024) -> RESPOND.
REQ-022 RESPOND: output byte addr[1:0] of the fill word; ready pulse for one cycle -> IDLE.
REQ-023 A wave_rd_i outside IDLE is held in a one-deep pending slot and serviced on the next IDLE cycle; a further request while the slot is full is dropped and sets overrun_o.
REQ-024 A glu_wr_i whose addr[15:2] matches a valid line clears that valid bit the same cycle; a match against the in-flight miss word marks the fill no-allocate (data still returned, line left invalid).
REQ-025 glu_wr_i and an invalidate-vs-lookup collision in the same cycle: the invalidate wins and the lookup is treated as a miss.
REQ-026 mem_ready_i outside MISS_WAIT is ignored.
REQ-027 wave_data_o holds its last value between ready pulses.

Reset
REQ-028 On reset_i: state IDLE, all valid bits 0, pending slot empty, overrun_o=0, mem_rd_o=0, wave_data_ready_o=0, wave_data_o=8'h00.
REQ-029 Reset mid-miss abandons the request; no ready pulse is produced and the late mem_ready_i is ignored.

Structure
REQ-030 Shared sound package holds the FSM state enum, SOUND_RAM_BASE_WORD and the line-count constant.
REQ-031 Optional sub-module doc_wave_line_store (4x32 data, valid bits, tag compare); everything else stays flat.

Verification
REQ-032 Cold read: wave_rd_i with addr 16'h1235, memory returns 32'hDDCCBBAA -> mem_addr_o=21'h01_048D, wave_data_o=8'hBB, one ready pulse.
REQ-033 Hit: read 16'h1236 next -> no mem_rd_o; wave_data_o=8'hCC two cycles after wave_rd_i.
REQ-034 Invalidate: glu_wr_i to 16'h1234, then read 16'h1234 -> new mem_rd_o issued.
REQ-035 Back-to-back: three wave_rd_i during a miss -> the first two complete in order; overrun_o=1.
REQ-036 Reset asserted in MISS_WAIT, then mem_ready_i -> no ready pulse; all lines invalid.
REQ-037 ENABLE=0: any read -> mem_rd_o never asserted; wave_data_o=8'h00 with a ready pulse.
